// File: rtl/pattern_queue_if.sv
// Bus bundle for the rhythm-game note queue: chart pushes, beat/hit inputs,
// and the judged GOOD/BAD/MISS pulses going out to scoring.
interface pattern_queue_if #(
   parameter int LANES = 4,
   parameter int DEPTH = 16
);
   localparam int LW = $clog2(DEPTH + 1);

   logic             CLR;
   logic [LANES-1:0] I;
   logic             WE;
   logic             TICK;
   logic [LANES-1:0] HIT;
   logic             FULL;
   logic             EMPTY;
   logic [LW-1:0]    LEVEL;
   logic             OVF;
   logic [LANES-1:0] O;
   logic [LANES-1:0] GOOD;
   logic [LANES-1:0] BAD;
   logic [LANES-1:0] MISS;

   modport master (
      output CLR, I, WE, TICK, HIT,
      input  FULL, EMPTY, LEVEL, OVF, O, GOOD, BAD, MISS
   );

   modport slave (
      input  CLR, I, WE, TICK, HIT,
      output FULL, EMPTY, LEVEL, OVF, O, GOOD, BAD, MISS
   );
endinterface

// File: rtl/pattern_queue.sv
// Circular queue of note rows feeding a hit-line head register; judges button
// pulses against the head and emits registered per-lane GOOD/BAD/MISS pulses.
module pattern_queue #(
   parameter int LANES = 4,
   parameter int DEPTH = 16
) (
   input logic             C,
   input logic             INIT_N,
   pattern_queue_if.slave  bus
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [LANES-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             ovf_q, ovf_d;
   logic [LANES-1:0] head_q, head_d;
   logic [LANES-1:0] good_q, good_d;
   logic [LANES-1:0] bad_q, bad_d;
   logic [LANES-1:0] miss_q, miss_d;
   logic             pushOk;
   logic             pop;
   logic             memWe;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full queue still accepts a push on TICK because the pop frees a slot the same edge.
   assign pushOk = bus.WE && ((level_q != LW'(DEPTH)) || bus.TICK);
   assign pop    = bus.TICK && (level_q != '0);

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      head_d  = head_q;
      good_d  = '0;
      bad_d   = '0;
      miss_d  = '0;
      memWe   = 1'b0;
      if (bus.CLR) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         level_d = '0;
         ovf_d   = 1'b0;
         head_d  = '0;
      end else begin
         good_d = bus.HIT & head_q;
         bad_d  = bus.HIT & ~head_q;
         if (bus.TICK) begin
            miss_d = head_q & ~bus.HIT;
            head_d = pop ? mem_q[rdPtr_q] : '0;
            if (pop) rdPtr_d = nextPtr(rdPtr_q);
         end else begin
            head_d = head_q & ~bus.HIT;
         end
         if (bus.WE) begin
            if (pushOk) begin
               memWe   = 1'b1;
               wrPtr_d = nextPtr(wrPtr_q);
            end else begin
               ovf_d = 1'b1;
            end
         end
         if (pushOk && !pop)      level_d = level_q + LW'(1);
         else if (!pushOk && pop) level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge C or negedge INIT_N) begin
      if (!INIT_N) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         head_q  <= '0;
         good_q  <= '0;
         bad_q   <= '0;
         miss_q  <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         head_q  <= head_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         miss_q  <= miss_d;
      end
   end

   // Row storage is never reset; only pointers and LEVEL define validity.
   always_ff @(posedge C) begin
      if (memWe) mem_q[wrPtr_q] <= bus.I;
   end

   assign bus.FULL  = (level_q == LW'(DEPTH));
   assign bus.EMPTY = (level_q == '0);
   assign bus.LEVEL = level_q;
   assign bus.OVF   = ovf_q;
   assign bus.O     = head_q;
   assign bus.GOOD  = good_q;
   assign bus.BAD   = bad_q;
   assign bus.MISS  = miss_q;
endmodule

// File: tb/tb_pattern_queue.sv
// Directed bench for pattern_queue: status, overflow/wrap, hit judging,
// clear priority and asynchronous reset, all against hand-computed values.
module tb_pattern_queue;
   localparam int LANES = 4;
   localparam int DEPTH = 16;

   logic C;
   logic INIT_N;
   int   vectors;
   int   miscompares;

   pattern_queue_if #(.LANES(LANES), .DEPTH(DEPTH)) bus ();

   pattern_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .C      (C),
      .INIT_N (INIT_N),
      .bus    (bus.slave)
   );

   initial begin
      C = 1'b0;
      forever #5 C = ~C;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // One clock of stimulus; returns 1 time unit after the edge with inputs idle.
   task automatic applyStimulus(input logic we, input logic [LANES-1:0] din,
                                input logic tick, input logic [LANES-1:0] hit,
                                input logic clr);
      bus.WE   = we;
      bus.I    = din;
      bus.TICK = tick;
      bus.HIT  = hit;
      bus.CLR  = clr;
      @(posedge C);
      #1;
      bus.WE   = 1'b0;
      bus.I    = '0;
      bus.TICK = 1'b0;
      bus.HIT  = '0;
      bus.CLR  = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      INIT_N      = 1'b0;
      bus.WE = 1'b0; bus.I = '0; bus.TICK = 1'b0; bus.HIT = '0; bus.CLR = 1'b0;
      repeat (3) @(posedge C);
      #2 INIT_N = 1'b1;

      checkOutput("rst_O", 32'(bus.O), 32'h0);
      checkOutput("rst_LEVEL", 32'(bus.LEVEL), 32'd0);
      checkOutput("rst_EMPTY", 32'(bus.EMPTY), 32'd1);
      checkOutput("rst_FULL", 32'(bus.FULL), 32'd0);
      checkOutput("rst_OVF", 32'(bus.OVF), 32'd0);

      applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b1, 4'b0110, 1'b0, 4'b0000, 1'b0);
      checkOutput("push2_LEVEL", 32'(bus.LEVEL), 32'd2);
      checkOutput("push2_EMPTY", 32'(bus.EMPTY), 32'd0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      checkOutput("tick1_O", 32'(bus.O), 32'h1);
      checkOutput("tick1_LEVEL", 32'(bus.LEVEL), 32'd1);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      checkOutput("tick2_O", 32'(bus.O), 32'h6);
      checkOutput("tick2_LEVEL", 32'(bus.LEVEL), 32'd0);
      checkOutput("tick2_EMPTY", 32'(bus.EMPTY), 32'd1);
      checkOutput("tick2_MISS", 32'(bus.MISS), 32'h1);

      // Hit judging on O=0110
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0);
      checkOutput("hit1_GOOD", 32'(bus.GOOD), 32'h4);
      checkOutput("hit1_BAD", 32'(bus.BAD), 32'h0);
      checkOutput("hit1_O", 32'(bus.O), 32'h2);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0101, 1'b0);
      checkOutput("hit2_GOOD", 32'(bus.GOOD), 32'h0);
      checkOutput("hit2_BAD", 32'(bus.BAD), 32'h5);
      checkOutput("hit2_O", 32'(bus.O), 32'h2);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      checkOutput("miss_MISS", 32'(bus.MISS), 32'h2);
      checkOutput("miss_BAD", 32'(bus.BAD), 32'h0);
      checkOutput("miss_O", 32'(bus.O), 32'h0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);
      checkOutput("pulse_MISS", 32'(bus.MISS), 32'h0);

      // Simultaneous HIT+TICK
      applyStimulus(1'b1, 4'b1011, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      checkOutput("ht_pre_O", 32'(bus.O), 32'hB);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0);
      checkOutput("ht_GOOD", 32'(bus.GOOD), 32'h1);
      checkOutput("ht_BAD", 32'(bus.BAD), 32'h0);
      checkOutput("ht_MISS", 32'(bus.MISS), 32'hA);
      checkOutput("ht_O", 32'(bus.O), 32'h8);
      checkOutput("ht_LEVEL", 32'(bus.LEVEL), 32'd0);

      // Empty scroll with push: no bypass
      applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0);
      checkOutput("nobyp_O", 32'(bus.O), 32'h0);
      checkOutput("nobyp_LEVEL", 32'(bus.LEVEL), 32'd1);
      checkOutput("nobyp_MISS", 32'(bus.MISS), 32'h8);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      checkOutput("nobyp2_O", 32'(bus.O), 32'hF);
      checkOutput("nobyp2_LEVEL", 32'(bus.LEVEL), 32'd0);

      // Fill/overflow/wrap with pointers starting mid-array
      for (int k = 0; k < DEPTH; k++)
         applyStimulus(1'b1, 4'(k), 1'b0, 4'b0000, 1'b0);
      checkOutput("fill_FULL", 32'(bus.FULL), 32'd1);
      checkOutput("fill_LEVEL", 32'(bus.LEVEL), 32'd16);
      checkOutput("fill_OVF", 32'(bus.OVF), 32'd0);
      applyStimulus(1'b1, 4'hF, 1'b0, 4'b0000, 1'b0);
      checkOutput("drop_OVF", 32'(bus.OVF), 32'd1);
      checkOutput("drop_LEVEL", 32'(bus.LEVEL), 32'd16);
      applyStimulus(1'b1, 4'hF, 1'b1, 4'b0000, 1'b0);
      checkOutput("fulltick_LEVEL", 32'(bus.LEVEL), 32'd16);
      checkOutput("fulltick_O", 32'(bus.O), 32'h0);
      for (int k = 1; k <= DEPTH; k++) begin
         applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
         checkOutput($sformatf("drain%0d_O", k), 32'(bus.O),
                     (k == DEPTH) ? 32'hF : 32'(k));
      end
      checkOutput("drain_EMPTY", 32'(bus.EMPTY), 32'd1);
      checkOutput("drain_OVF", 32'(bus.OVF), 32'd1);

      // CLR with TICK pending: clear wins, no MISS for the live head
      for (int k = 1; k <= 6; k++)
         applyStimulus(1'b1, 4'(k), 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      checkOutput("preclr_LEVEL", 32'(bus.LEVEL), 32'd5);
      checkOutput("preclr_O", 32'(bus.O), 32'h1);
      applyStimulus(1'b1, 4'h7, 1'b1, 4'b0011, 1'b1);
      checkOutput("clr_LEVEL", 32'(bus.LEVEL), 32'd0);
      checkOutput("clr_O", 32'(bus.O), 32'h0);
      checkOutput("clr_OVF", 32'(bus.OVF), 32'd0);
      checkOutput("clr_MISS", 32'(bus.MISS), 32'h0);
      checkOutput("clr_GOOD", 32'(bus.GOOD), 32'h0);
      checkOutput("clr_EMPTY", 32'(bus.EMPTY), 32'd1);

      // Refill then async reset between edges
      applyStimulus(1'b1, 4'h9, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b1, 4'hA, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b1, 4'hC, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      checkOutput("refill_O", 32'(bus.O), 32'h9);
      checkOutput("refill_LEVEL", 32'(bus.LEVEL), 32'd2);
      #2 INIT_N = 1'b0;
      #1;
      checkOutput("async_O", 32'(bus.O), 32'h0);
      checkOutput("async_LEVEL", 32'(bus.LEVEL), 32'd0);
      checkOutput("async_EMPTY", 32'(bus.EMPTY), 32'd1);
      checkOutput("async_MISS", 32'(bus.MISS), 32'h0);
      @(posedge C);
      #2 INIT_N = 1'b1;
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
      checkOutput("postrst_O", 32'(bus.O), 32'h0);
      checkOutput("postrst_MISS", 32'(bus.MISS), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pattern_queue.md
Name: pattern_queue

Overview:
- Parametrised successor to the single-row pattern register: a LANES-wide, DEPTH-deep circular queue of note rows for the rhythm game.
- The chart generator pushes rows. A beat TICK scrolls the oldest row into a head ("hit line") register. The head is then judged against player button pulses.
- Produces per-lane GOOD/BAD/MISS pulses for the score logic.
- Sits between chart/pattern generation and the scoring/display blocks.

Parameters:
- LANES, 4, number of note lanes (bit width of every row); LANES >= 1.
- DEPTH, 16, number of queued rows excluding the head register; DEPTH >= 2, need not be a power of 2.
- LW (localparam), $clog2(DEPTH+1), width of LEVEL.

Ports:
- C  in  1  clock; all state changes on the rising edge.
- INIT_N  in  1  reset, asynchronous, active-low.
- CLR  in  1  synchronous clear: queue empty, head 0, OVF 0, pulses 0.
- I  in  LANES  row to push.
- WE  in  1  push request; accepted when !FULL or TICK in the same cycle.
- FULL  out  1  LEVEL == DEPTH.
- EMPTY  out  1  LEVEL == 0.
- LEVEL  out  LW  number of queued rows (head not counted).
- OVF  out  1  sticky; set when a push is dropped.
- TICK  in  1  one-cycle beat strobe; scrolls the queue.
- HIT  in  LANES  one-cycle button pulses, already debounced/edged upstream.
- O  out  LANES  current head row; bits still awaiting a hit.
- GOOD  out  LANES  registered pulse, HIT & O.
- BAD  out  LANES  registered pulse, HIT & ~O.
- MISS  out  LANES  registered pulse on scroll: unhit bits of the departing head.

Behaviour:
- Reset (INIT_N=0, async): pointers 0, LEVEL 0, EMPTY 1, FULL 0, O 0, GOOD/BAD/MISS 0, OVF 0. Storage contents are don't-care.
- CLR=1: same values as reset, applied synchronously. CLR has priority over WE/TICK/HIT in that cycle, and no pulses are produced.
- Storage: DEPTH x LANES array with rd_ptr/wr_ptr. Each pointer wraps from DEPTH-1 to 0. LEVEL is a counter, not derived from pointer difference.
- Push: on WE, if LEVEL<DEPTH or TICK=1, write I at wr_ptr and advance wr_ptr. Otherwise drop the row and set OVF=1.
- Scroll (TICK=1):
  - If LEVEL>0: O <= mem[rd_ptr], rd_ptr advances.
  - If LEVEL==0: O <= 0.
- Push on TICK when empty: no bypass. O <= 0 this cycle; the pushed row enters storage and appears on O at a later TICK.
- LEVEL update: +1 on accepted push without pop; -1 on pop without push; unchanged on simultaneous push+pop or on neither.
- Judging, evaluated on the pre-edge O, with all pulses registered (one-cycle latency, high for exactly one cycle):
  - GOOD <= HIT & O.
  - BAD <= HIT & ~O.
  - Without TICK: O <= O & ~HIT (a hit lane is consumed; a second hit on it yields BAD).
  - With TICK: MISS <= O & ~HIT; O then loads the next row per the scroll rule.
- HIT and TICK in the same cycle: the hit scores against the departing head (GOOD), and that lane is excluded from MISS.
- No combinational path from inputs to outputs. FULL, EMPTY and LEVEL reflect registered state.
- Reset asserted mid-operation clears everything immediately. Queued rows are lost, and no MISS is emitted for them.

Test Plan:
- Reset and status: hold INIT_N=0, then release -> O=0, LEVEL=0, EMPTY=1, FULL=0, OVF=0. Push 4'b0001, 4'b0110 -> LEVEL=2. TICK -> O=0001; TICK -> O=0110, LEVEL=0.
- Fill, overflow and wrap: push 16 rows 0..15 -> FULL=1. Push 4'hF without TICK -> dropped, OVF=1, LEVEL=16. WE+TICK together -> accepted, LEVEL stays 16, O=0. Drain with 16 TICKs -> O sequence 1..15 then F, confirming wr_ptr/rd_ptr wrap.
- Hit judging: O=0110, HIT=0100 -> next cycle GOOD=0100, O=0010. HIT=0101 -> GOOD=0000, BAD=0101. TICK with O=0010 and no HIT -> MISS=0010.
- Simultaneous HIT+TICK: O=1011, HIT=0001 with TICK, next queued row 1000 -> GOOD=0001, MISS=1010, O=1000.
- Empty scroll and no bypass: LEVEL=0, WE with I=1111 and TICK together -> O=0000, LEVEL=1. Next TICK -> O=1111.
- Clear and async reset mid-stream: with LEVEL=5 and OVF=1, pulse CLR -> LEVEL=0, O=0, OVF=0, no MISS pulse. Refill 3 rows, then drop INIT_N between edges -> outputs reset immediately without waiting for an edge of C.
